// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic multiplier front end.
package systolic_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ACC_W_DEF   = 16;
    localparam int NUM_SLOTS   = 8;
    localparam int FEED_CYCLES = 3;

    // Buffer slots follow the serial arrival order of the operand stream.
    localparam int A00 = 0;
    localparam int A01 = 1;
    localparam int A10 = 2;
    localparam int A11 = 3;
    localparam int B00 = 4;
    localparam int B01 = 5;
    localparam int B10 = 6;
    localparam int B11 = 7;

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Operand stream, array edge and result stream signals of the feed controller.
interface systolic_feed_ctrl_if
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic [DATA_W-1:0] a_row0;
    logic [DATA_W-1:0] a_row1;
    logic [DATA_W-1:0] b_col0;
    logic [DATA_W-1:0] b_col1;
    logic              pe_clear;

    logic [ACC_W-1:0]  c00;
    logic [ACC_W-1:0]  c01;
    logic [ACC_W-1:0]  c10;
    logic [ACC_W-1:0]  c11;

    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  r00;
    logic [ACC_W-1:0]  r01;
    logic [ACC_W-1:0]  r10;
    logic [ACC_W-1:0]  r11;
    logic              busy;

    // master: the surroundings (source, array, sink); slave: the controller.
    modport master (
        output in_valid, in_data, res_ready, c00, c01, c10, c11,
        input  in_ready, a_row0, a_row1, b_col0, b_col1, pe_clear,
               res_valid, r00, r01, r10, r11, busy
    );

    modport slave (
        input  in_valid, in_data, res_ready, c00, c01, c10, c11,
        output in_ready, a_row0, a_row1, b_col0, b_col1, pe_clear,
               res_valid, r00, r01, r10, r11, busy
    );

endinterface

// File: rtl/systolic_feed_ctrl_skew_sched.sv
// Skewed operand schedule: maps feed index k and the buffered matrices to edge operands.
module skew_sched
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              en_i,
    input  logic [1:0]        k_i,
    input  logic [DATA_W-1:0] buf_i [NUM_SLOTS],
    output logic [DATA_W-1:0] a_row0_o,
    output logic [DATA_W-1:0] a_row1_o,
    output logic [DATA_W-1:0] b_col0_o,
    output logic [DATA_W-1:0] b_col1_o
);

    always_comb begin
        a_row0_o = '0;
        a_row1_o = '0;
        b_col0_o = '0;
        b_col1_o = '0;
        if (en_i) begin
            case (k_i)
                2'd0: begin
                    a_row0_o = buf_i[A00];
                    b_col0_o = buf_i[B00];
                end
                2'd1: begin
                    a_row0_o = buf_i[A01];
                    a_row1_o = buf_i[A10];
                    b_col0_o = buf_i[B10];
                    b_col1_o = buf_i[B01];
                end
                2'd2: begin
                    a_row1_o = buf_i[A11];
                    b_col1_o = buf_i[B11];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Front-end controller for the 2x2 systolic multiplier: buffers two matrices,
// feeds the skewed operands into the array and hands the captured products downstream.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    systolic_feed_ctrl_if.slave bus
);

    state_e            state_q;
    logic [2:0]        beat_cnt_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] buf_q [NUM_SLOTS];

    logic [DATA_W-1:0] a_row0_q, a_row1_q, b_col0_q, b_col1_q;
    logic [DATA_W-1:0] a_row0_d, a_row1_d, b_col0_d, b_col1_d;
    logic              pe_clear_q;
    logic              res_valid_q;
    logic [ACC_W-1:0]  r00_q, r01_q, r10_q, r11_q;

    logic              sched_en;
    logic [1:0]        sched_k;

    // Operands are registered, so the schedule looks one feed step ahead of cnt_q.
    always_comb begin
        sched_en = 1'b0;
        sched_k  = '0;
        case (state_q)
            CLEAR: sched_en = 1'b1;
            FEED: begin
                if (cnt_q != 4'(FEED_CYCLES - 1)) begin
                    sched_en = 1'b1;
                    sched_k  = cnt_q[1:0] + 2'd1;
                end
            end
            default: ;
        endcase
    end

    skew_sched #(
        .DATA_W (DATA_W)
    ) u_skew_sched (
        .en_i     (sched_en),
        .k_i      (sched_k),
        .buf_i    (buf_q),
        .a_row0_o (a_row0_d),
        .a_row1_o (a_row1_d),
        .b_col0_o (b_col0_d),
        .b_col1_o (b_col1_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            beat_cnt_q  <= '0;
            cnt_q       <= '0;
            pe_clear_q  <= 1'b0;
            a_row0_q    <= '0;
            a_row1_q    <= '0;
            b_col0_q    <= '0;
            b_col1_q    <= '0;
            res_valid_q <= 1'b0;
            r00_q       <= '0;
            r01_q       <= '0;
            r10_q       <= '0;
            r11_q       <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            pe_clear_q <= 1'b0;
            a_row0_q   <= a_row0_d;
            a_row1_q   <= a_row1_d;
            b_col0_q   <= b_col0_d;
            b_col1_q   <= b_col1_d;
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        buf_q[beat_cnt_q] <= bus.in_data;
                        if (beat_cnt_q == 3'(NUM_SLOTS - 1)) begin
                            beat_cnt_q <= '0;
                            pe_clear_q <= 1'b1;
                            state_q    <= CLEAR;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 3'd1;
                        end
                    end
                end
                CLEAR: begin
                    cnt_q   <= '0;
                    state_q <= FEED;
                end
                FEED: begin
                    if (cnt_q == 4'(FEED_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 4'(DRAIN_CYCLES - 1)) begin
                        cnt_q       <= '0;
                        res_valid_q <= 1'b1;
                        r00_q       <= bus.c00;
                        r01_q       <= bus.c01;
                        r10_q       <= bus.c10;
                        r11_q       <= bus.c11;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.busy      = (state_q != LOAD);
    assign bus.pe_clear  = pe_clear_q;
    assign bus.a_row0    = a_row0_q;
    assign bus.a_row1    = a_row1_q;
    assign bus.b_col0    = b_col0_q;
    assign bus.b_col1    = b_col1_q;
    assign bus.res_valid = res_valid_q;
    assign bus.r00       = r00_q;
    assign bus.r01       = r01_q;
    assign bus.r10       = r10_q;
    assign bus.r11       = r11_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: a behavioural 2x2 systolic array closes the loop,
// and products are checked against a plain matrix-multiply reference.
module tb_systolic_feed_ctrl;
    import systolic_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DRAIN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_feed_ctrl_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

    systolic_feed_ctrl #(
        .DATA_W       (DW),
        .ACC_W        (AW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Output-stationary array: a flows right, b flows down, one register per hop.
    logic [AW-1:0] acc00, acc01, acc10, acc11;
    logic [DW-1:0] ah00, ah10, bv00, bv01;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            ah00 <= '0; ah10 <= '0; bv00 <= '0; bv01 <= '0;
        end else begin
            ah00 <= bus.a_row0;
            ah10 <= bus.a_row1;
            bv00 <= bus.b_col0;
            bv01 <= bus.b_col1;
            if (bus.pe_clear) begin
                acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            end else begin
                acc00 <= acc00 + AW'(bus.a_row0) * AW'(bus.b_col0);
                acc01 <= acc01 + AW'(ah00) * AW'(bus.b_col1);
                acc10 <= acc10 + AW'(bus.a_row1) * AW'(bv00);
                acc11 <= acc11 + AW'(ah10) * AW'(bv01);
            end
        end
    end

    assign bus.c00 = acc00;
    assign bus.c01 = acc01;
    assign bus.c10 = acc10;
    assign bus.c11 = acc11;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    logic [7:0]  mat   [8];
    logic [15:0] exp_r [4];

    // C = A*B with A, B row-major in the stream order, truncated to the result width.
    function automatic void model();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 2; k++) s += int'(mat[i*2+k]) * int'(mat[4+k*2+j]);
                exp_r[i*2+j] = 16'(s);
            end
        end
    endfunction

    function automatic logic [31:0] exp_sched(input int k);
        case (k)
            0:       return {mat[0], 8'd0, mat[4], 8'd0};
            1:       return {mat[1], mat[2], mat[6], mat[5]};
            2:       return {8'd0, mat[3], 8'd0, mat[7]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ops();
        return {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1};
    endfunction

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
        check_eq("in_ready_gap", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // gap: 0 continuous, 1 toggling, 2 random idle cycles between beats
    task automatic load(input int gap);
        for (int i = 0; i < 8; i++) begin
            if (gap == 1 && i > 0) idle_cycle();
            if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
            bus.in_valid = 1'b1;
            bus.in_data  = mat[i];
            @(negedge clk);
            check_eq("in_ready_beat", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Starts right after the 8th beat edge; ends just after the result handshake edge.
    task automatic finish_product(input int hold, input bit early);
        int first  = 0;
        int clears = 0;
        model();
        bus.res_ready = early;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.pe_clear) clears++;
            if (n == 1) begin
                check_eq("clear_ops", ops(), 32'd0);
                check_eq("clear_rdy_busy", 32'({bus.in_ready, bus.busy}), 32'b01);
            end else if (n <= 4) begin
                check_eq($sformatf("feed_k%0d", n - 2), ops(), exp_sched(n - 2));
            end else if (bus.res_valid) begin
                first = n;
                break;
            end else begin
                check_eq("drain_ops", ops(), 32'd0);
            end
        end
        check_eq("res_latency", 32'(first), 32'(DRAIN + 5));
        check_eq("pe_clear_once", 32'(clears), 32'd1);
        check_eq("r00", 32'(bus.r00), 32'(exp_r[0]));
        check_eq("r01", 32'(bus.r01), 32'(exp_r[1]));
        check_eq("r10", 32'(bus.r10), 32'(exp_r[2]));
        check_eq("r11", 32'(bus.r11), 32'(exp_r[3]));
        if (!early) begin
            repeat (hold) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b1;
                bus.in_data  = 8'($urandom);
                @(negedge clk);
                check_eq("hold_valid", 32'(bus.res_valid), 32'd1);
                check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check_eq("hold_r_hi", {bus.r00, bus.r01}, {exp_r[0], exp_r[1]});
                check_eq("hold_r_lo", {bus.r10, bus.r11}, {exp_r[2], exp_r[3]});
            end
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check_eq("post_hs_valid", 32'(bus.res_valid), 32'd0);
        check_eq("post_hs_rdy_busy", 32'({bus.in_ready, bus.busy}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_busy_clr_val", 32'({bus.busy, bus.pe_clear, bus.res_valid}), 32'd0);
        check_eq("rst_ops", ops(), 32'd0);
        check_eq("rst_r", 32'(bus.r00 | bus.r01 | bus.r10 | bus.r11), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        mat = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load(0);
        finish_product(0, 1'b1);
        check_eq("basic_r", {bus.r00, bus.r01}, {16'd19, 16'd22});
        check_eq("basic_r2", {bus.r10, bus.r11}, {16'd43, 16'd50});

        load(1);
        finish_product(0, 1'b0);

        foreach (mat[i]) mat[i] = 8'd255;
        load(2);
        finish_product(0, 1'b1);
        check_eq("sat_r00", 32'(bus.r00), 32'd64514);
        check_eq("sat_r11", 32'(bus.r11), 32'd64514);

        foreach (mat[i]) mat[i] = 8'($urandom);
        load(0);
        finish_product(10, 1'b0);

        foreach (mat[i]) mat[i] = 8'($urandom_range(1, 255));
        load(0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_feed_k1", ops(), exp_sched(1));
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_ops", ops(), 32'd0);
        check_eq("midrst_flags", 32'({bus.in_ready, bus.busy, bus.pe_clear, bus.res_valid}), 32'b1000);
        check_eq("midrst_r", 32'(bus.r00 | bus.r01 | bus.r10 | bus.r11), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        mat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
        load(0);
        finish_product(0, 1'b1);
        check_eq("ident_r", {bus.r00, bus.r01}, {16'd9, 16'd8});
        check_eq("ident_r2", {bus.r10, bus.r11}, {16'd7, 16'd6});

        for (int t = 0; t < 6; t++) begin
            foreach (mat[i]) mat[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            load(int'($urandom_range(0, 2)));
            finish_product(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Front-end controller for the 2x2 systolic multiplier. It accepts two 2x2 matrices as a serial byte stream over a valid/ready handshake and buffers them. It then clears the array accumulators and drives the skewed row/column operand streams into the array's edge PEs. After a fixed drain interval it captures the four accumulator outputs and presents them downstream over a second valid/ready handshake.

## Interface
- DATA_W, 8, operand width
- ACC_W, 16, accumulator/result width
- DRAIN_CYCLES, 4, cycles after the last feed cycle before results are captured (range 1..15)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  controller accepts a beat
- in_data  in  DATA_W  element, fixed order: a00,a01,a10,a11,b00,b01,b10,b11
- a_row0, a_row1  out  DATA_W  operands into left edge of rows 0/1
- b_col0, b_col1  out  DATA_W  operands into top edge of columns 0/1
- pe_clear  out  1  synchronous accumulator clear to the array
- c00, c01, c10, c11  in  ACC_W  array accumulator outputs
- res_valid  out  1  result registers hold a complete product
- res_ready  in  1  downstream accepts the result
- r00, r01, r10, r11  out  ACC_W  captured results
- busy  out  1  high in every state except LOAD

## Operation
- States: LOAD -> CLEAR -> FEED -> DRAIN -> DONE -> LOAD.
- LOAD:
  - in_ready=1. Each in_valid&in_ready beat writes in_data into buffer slot beat_cnt (0..7) and increments beat_cnt.
  - Gaps in in_valid are allowed.
  - The beat that writes slot 7 moves the FSM to CLEAR and resets beat_cnt to 0.
- CLEAR: one cycle, pe_clear=1, all operand outputs 0.
- FEED: three cycles, k=0..2. The operand registers show:
  - k=0: a_row0=a00, b_col0=b00, others 0.
  - k=1: a_row0=a01, a_row1=a10, b_col0=b10, b_col1=b01.
  - k=2: a_row0=0, b_col0=0, a_row1=a11, b_col1=b11.
- DRAIN:
  - All operand outputs are 0 for DRAIN_CYCLES cycles.
  - On the last DRAIN cycle, c00..c11 are registered into r00..r11 and the FSM enters DONE.
- DONE:
  - res_valid=1. r00..r11 are stable until the handshake.
  - res_valid&res_ready returns the FSM to LOAD. No new input is accepted in DONE.
- Arithmetic: the controller performs no arithmetic on results. It captures the ACC_W values verbatim, so any overflow wraps inside the array.
- Buffer contents persist until overwritten. Only the 8 slots are stored.

## Timing
- Reset values:
  - State LOAD, beat_cnt=0, feed/drain counter=0.
  - All operand outputs 0, pe_clear=0, res_valid=0.
  - r00..r11 = 0, busy=0, buffer cleared to 0.
- in_ready and busy are decoded combinationally from the state. in_ready reads 1 while the controller is in LOAD, including during reset.
- pe_clear, operand outputs, res_valid and r00..r11 are registered.
- pe_clear is high in the cycle after the 8th beat handshake.
- FEED k=0 values appear on the following edge.
- res_valid rises DRAIN_CYCLES+4 cycles after the 8th beat edge.
- Latency from the 8th beat to res_valid is DRAIN_CYCLES+5 cycles, with no backpressure.
- res_ready held high early has no effect. It is sampled only while res_valid=1. A handshake on the first DONE cycle gives a one-cycle res_valid pulse.
- Throughput: one product per 8 + 1 + 3 + DRAIN_CYCLES + 1 cycles minimum.
- Reset asserted mid-operation (any state):
  - Immediate return to reset values, with partial input discarded.
  - Operand outputs go to 0 asynchronously.
  - The array must share the same reset.

## Structure
- Shared package systolic_pkg holds:
  - DATA_W/ACC_W defaults.
  - The state enum (LOAD, CLEAR, FEED, DRAIN, DONE).
  - Buffer slot index constants (A00=0 … B11=7).
  - FEED_CYCLES=3.
- One sub-module, skew_sched: a combinational mapping from feed index k and the buffer to the four operand values. It is registered in the parent.
- The FSM, counters, buffer and result registers live in the top.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_valid continuous, res_ready=1, paired with the array -> r00=19, r01=22, r10=43, r11=50; res_valid at cycle DRAIN_CYCLES+5 after the 8th beat.
- Same matrices with in_valid toggling 1/0 every cycle -> identical results; in_ready stays 1 throughout LOAD; the FEED schedule matches the k=0..2 list exactly.
- All elements 255 -> r00..r11 = 64514 (130050 mod 2^16).
- res_ready held 0 for 10 cycles in DONE -> res_valid and r00..r11 stable, in_ready=0, in_data beats ignored. Then res_ready=1 -> LOAD next cycle.
- Reset pulse during FEED k=1 -> all outputs 0, state LOAD. A fresh 8-beat load of identity A, B=[[9,8],[7,6]] -> r=9,8,7,6.
- Back-to-back products: second load starts the cycle after the handshake -> no stale accumulation; pe_clear is seen once per product.
